// File: rtl/wb_trace_capture.sv
// Write-back trace capture: circular history of register-file writes with a PC trigger and oldest-first drain.
// Optional feature macro: TRACE_TSTAMP_EN adds a TS_W-bit cycle timestamp to the top of each entry.
module wb_trace_capture #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 16,
    parameter int TS_W       = 16,
    localparam int CW        = $clog2(DEPTH) + 1,
`ifdef TRACE_TSTAMP_EN
    localparam int ENTRY_W   = XLEN + REG_ADDR_W + XLEN + TS_W
`else
    localparam int ENTRY_W   = XLEN + REG_ADDR_W + XLEN + 0 * TS_W
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_wb_en,
    input  logic [REG_ADDR_W-1:0] i_wb_rd,
    input  logic [XLEN-1:0]       i_wb_data,
    input  logic [XLEN-1:0]       i_wb_pc,
    input  logic                  i_arm,
    input  logic [XLEN-1:0]       i_trig_pc,
    input  logic [CW-1:0]         i_post_cnt,
    output logic                  o_rd_valid,
    input  logic                  i_rd_ready,
    output logic [ENTRY_W-1:0]    o_rd_data,
    output logic [1:0]            o_state,
    output logic [CW-1:0]         o_count,
    output logic                  o_overflow
);
    localparam int AW = CW - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [CW-1:0]   remain_reg, remain_next;
    logic            overflow_reg, overflow_next;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] entry_in;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      post_clamped;
    logic               recorded, store, rd_valid, pop;

`ifdef TRACE_TSTAMP_EN
    logic [TS_W-1:0] ts_reg;

    // Free-running cycle stamp, restarted on arm so timestamps are relative to the capture window.
    always_ff @(posedge clk) begin
        if (reset || i_arm) ts_reg <= '0;
        else                ts_reg <= ts_reg + TS_W'(1);
    end

    assign entry_in = {ts_reg, i_wb_pc, i_wb_rd, i_wb_data};
`else
    assign entry_in = {i_wb_pc, i_wb_rd, i_wb_data};
`endif

    assign recorded     = i_wb_en && (i_wb_rd != '0);
    assign store        = recorded && !i_arm && (state_reg == ST_ARMED || state_reg == ST_POST);
    assign post_clamped = (i_post_cnt > CW'(DEPTH - 1)) ? CW'(DEPTH - 1) : i_post_cnt;
    // When the buffer is full the low bits of count are zero, so the oldest entry sits at wr_ptr.
    assign rd_ptr       = wr_ptr_reg - count_reg[AW-1:0];
    assign rd_valid     = (state_reg == ST_DONE) && (count_reg != '0);
    assign pop          = rd_valid && i_rd_ready;

    always_comb begin
        state_next    = state_reg;
        wr_ptr_next   = wr_ptr_reg;
        count_next    = count_reg;
        remain_next   = remain_reg;
        overflow_next = overflow_reg;
        if (i_arm) begin
            state_next    = ST_ARMED;
            wr_ptr_next   = '0;
            count_next    = '0;
            remain_next   = '0;
            overflow_next = 1'b0;
        end else begin
            case (state_reg)
                ST_ARMED, ST_POST: begin
                    if (store) begin
                        wr_ptr_next = wr_ptr_reg + AW'(1);
                        if (count_reg == CW'(DEPTH)) overflow_next = 1'b1;
                        else                         count_next    = count_reg + CW'(1);
                        if (state_reg == ST_ARMED) begin
                            if (i_wb_pc == i_trig_pc) begin
                                remain_next = post_clamped;
                                state_next  = (post_clamped == '0) ? ST_DONE : ST_POST;
                            end
                        end else begin
                            remain_next = remain_reg - CW'(1);
                            if (remain_reg == CW'(1)) state_next = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (pop) begin
                        count_next = count_reg - CW'(1);
                        if (count_reg == CW'(1)) state_next = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            remain_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wr_ptr_reg   <= wr_ptr_next;
            count_reg    <= count_next;
            remain_reg   <= remain_next;
            overflow_reg <= overflow_next;
        end
    end

    // Storage carries no reset; stale contents are unreachable once count is cleared.
    always_ff @(posedge clk) begin
        if (store && !reset) mem[wr_ptr_reg] <= entry_in;
    end

    assign o_rd_valid = rd_valid;
    assign o_rd_data  = rd_valid ? mem[rd_ptr] : '0;
    assign o_state    = state_reg;
    assign o_count    = count_reg;
    assign o_overflow = overflow_reg;
endmodule

// File: tb/tb_wb_trace_capture.sv
// Directed bench for wb_trace_capture: capture, overflow, post count, clamp, x0/arm priority, backpressure, reset.
module tb_wb_trace_capture;
    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam int CW   = 5;
    localparam int TSW  = 16;
    localparam int LW   = XLEN + RW + XLEN;
`ifdef TRACE_TSTAMP_EN
    localparam int EW   = LW + TSW;
`else
    localparam int EW   = LW;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            i_wb_en = 1'b0;
    logic [RW-1:0]   i_wb_rd = '0;
    logic [XLEN-1:0] i_wb_data = '0;
    logic [XLEN-1:0] i_wb_pc = '0;
    logic            i_arm = 1'b0;
    logic [XLEN-1:0] i_trig_pc = '0;
    logic [CW-1:0]   i_post_cnt = '0;
    logic            o_rd_valid;
    logic            i_rd_ready = 1'b0;
    logic [EW-1:0]   o_rd_data;
    logic [1:0]      o_state;
    logic [CW-1:0]   o_count;
    logic            o_overflow;

    int checks = 0;
    int failures = 0;

    wb_trace_capture #(.XLEN(XLEN), .REG_ADDR_W(RW), .DEPTH(16), .TS_W(TSW)) dut (
        .clk(clk), .reset(reset), .i_wb_en(i_wb_en), .i_wb_rd(i_wb_rd),
        .i_wb_data(i_wb_data), .i_wb_pc(i_wb_pc), .i_arm(i_arm),
        .i_trig_pc(i_trig_pc), .i_post_cnt(i_post_cnt), .o_rd_valid(o_rd_valid),
        .i_rd_ready(i_rd_ready), .o_rd_data(o_rd_data), .o_state(o_state),
        .o_count(o_count), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wb(input int rd, input int data, input int pc);
        i_wb_en = 1'b1; i_wb_rd = RW'(rd); i_wb_data = XLEN'(data); i_wb_pc = XLEN'(pc);
        tick();
        i_wb_en = 1'b0;
    endtask

    task automatic arm(input int trig, input int post);
        i_trig_pc = XLEN'(trig); i_post_cnt = CW'(post); i_arm = 1'b1;
        tick();
        i_arm = 1'b0;
    endtask

    function automatic logic [127:0] low(input int rd, input int data, input int pc);
        logic [LW-1:0] e;
        e = {XLEN'(pc), RW'(rd), XLEN'(data)};
        return 128'(e);
    endfunction

    initial begin
        int idx;
        int cyc;
        logic [TSW-1:0] ts_a;
        logic [TSW-1:0] ts_b;

        // Reset state
        tick(); tick();
        check("rst_state", 128'(o_state), 128'(0));
        check("rst_count", 128'(o_count), 128'(0));
        check("rst_valid", 128'(o_rd_valid), 128'(0));
        check("rst_data", 128'(o_rd_data), 128'(0));
        check("rst_ovf", 128'(o_overflow), 128'(0));
        reset = 1'b0;
        wb(1, 'h99, 'h8);
        check("idle_ignore_count", 128'(o_count), 128'(0));

        // Basic capture and drain
        arm('h8, 0);
        check("arm_state", 128'(o_state), 128'(1));
        wb(1, 'hA, 'h0);
        wb(2, 'hB, 'h4);
        check("basic_mid_state", 128'(o_state), 128'(1));
        wb(3, 'hC, 'h8);
        check("basic_state", 128'(o_state), 128'(3));
        check("basic_count", 128'(o_count), 128'(3));
        i_rd_ready = 1'b1;
        check("basic_e0", 128'(o_rd_data[LW-1:0]), low(1, 'hA, 'h0)); tick();
        check("basic_e1", 128'(o_rd_data[LW-1:0]), low(2, 'hB, 'h4)); tick();
        check("basic_e2", 128'(o_rd_data[LW-1:0]), low(3, 'hC, 'h8)); tick();
        i_rd_ready = 1'b0;
        check("basic_end_state", 128'(o_state), 128'(0));
        check("basic_end_valid", 128'(o_rd_valid), 128'(0));

        // Overflow: 20 writes into 16 entries, trigger on the last one
        arm(19 * 4, 0);
        for (int i = 0; i < 20; i++) wb(1 + (i % 31), i, i * 4);
        check("ovf_state", 128'(o_state), 128'(3));
        check("ovf_flag", 128'(o_overflow), 128'(1));
        check("ovf_count", 128'(o_count), 128'(16));
        i_rd_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("ovf_data%0d", k), 128'(o_rd_data[XLEN-1:0]), 128'(k + 4));
            tick();
        end
        i_rd_ready = 1'b0;
        check("ovf_end_state", 128'(o_state), 128'(0));

        // Post count 3, second PC match during POST ignored, writes in DONE ignored
        arm('h100, 3);
        for (int i = 0; i < 12; i++) begin
            wb(5, i, (i == 5 || i == 7) ? 'h100 : 'h200 + i * 4);
            if (i == 5) check("post_trig_state", 128'(o_state), 128'(2));
            if (i == 7) check("post_rematch_state", 128'(o_state), 128'(2));
            if (i == 8) check("post_done_state", 128'(o_state), 128'(3));
        end
        check("post_count", 128'(o_count), 128'(9));
        check("post_ovf", 128'(o_overflow), 128'(0));

        // Backpressure drain: data must hold while not ready, no duplicates or losses
        idx = 0;
        cyc = 0;
        while (idx < 9 && cyc < 200) begin
            i_rd_ready = 1'($urandom_range(0, 1));
            #0;
            check($sformatf("bp_valid%0d", cyc), 128'(o_rd_valid), 128'(1));
            check($sformatf("bp_data%0d", cyc), 128'(o_rd_data[XLEN-1:0]), 128'(idx));
            tick();
            if (i_rd_ready) idx++;
            cyc++;
        end
        i_rd_ready = 1'b0;
        check("bp_all_popped", 128'(idx), 128'(9));
        check("bp_end_state", 128'(o_state), 128'(0));

        // Post count 20 clamps to 15
        arm('h300, 20);
        wb(6, 0, 'h300);
        for (int i = 1; i < 15; i++) wb(6, i, 'h300);
        check("clamp_still_post", 128'(o_state), 128'(2));
        wb(6, 15, 'h400);
        check("clamp_done", 128'(o_state), 128'(3));
        check("clamp_count", 128'(o_count), 128'(16));
        check("clamp_ovf", 128'(o_overflow), 128'(0));
        check("clamp_oldest", 128'(o_rd_data[XLEN-1:0]), 128'(0));

        // x0 writes and arm priority
        arm('h40, 0);
        wb(0, 'h11, 'h40);
        check("x0_state", 128'(o_state), 128'(1));
        check("x0_count", 128'(o_count), 128'(0));
        i_arm = 1'b1;
        wb(2, 'h55, 'h40);
        i_arm = 1'b0;
        check("armwr_state", 128'(o_state), 128'(1));
        check("armwr_count", 128'(o_count), 128'(0));
        wb(4, 'h77, 'h40);
        check("x0_after_state", 128'(o_state), 128'(3));
        check("x0_after_count", 128'(o_count), 128'(1));
        check("x0_after_entry", 128'(o_rd_data[LW-1:0]), low(4, 'h77, 'h40));

        // Reset in the middle of POST
        arm('h500, 5);
        wb(7, 1, 'h500);
        wb(7, 2, 'h504);
        check("midpost_state", 128'(o_state), 128'(2));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_state", 128'(o_state), 128'(0));
        check("mrst_count", 128'(o_count), 128'(0));
        check("mrst_valid", 128'(o_rd_valid), 128'(0));
        check("mrst_data", 128'(o_rd_data), 128'(0));
        check("mrst_ovf", 128'(o_overflow), 128'(0));

`ifdef TRACE_TSTAMP_EN
        // Two writes five edges apart carry stamps five apart
        arm('h620, 0);
        wb(8, 1, 'h610);
        tick(); tick(); tick(); tick();
        wb(8, 2, 'h620);
        check("ts_state", 128'(o_state), 128'(3));
        ts_a = o_rd_data[EW-1 -: TSW];
        i_rd_ready = 1'b1;
        tick();
        ts_b = o_rd_data[EW-1 -: TSW];
        tick();
        i_rd_ready = 1'b0;
        check("ts_delta", 128'(TSW'(ts_b - ts_a)), 128'(5));
`else
        ts_a = '0;
        ts_b = '0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_trace_capture.md
# wb_trace_capture

Parametrised write-back trace capture unit for the single-cycle CPU. It replaces per-cycle register-file dumping with a circular history of register-file writes, holding each write's PC, destination register and data. A PC-match trigger stops capture after a programmable number of post-trigger writes. The captured window is then drained oldest-first over a valid/ready port, by the bench or by a debug link. It sits beside `cpu_top`, tapping the decode-stage register-file write port.

## Interface
Parameters:
- `XLEN`, 32, data and PC width
- `REG_ADDR_W`, 5, register index width
- `DEPTH`, 16, entry count; power of two, at least 4
- `TS_W`, 16, timestamp width; used only with `TRACE_TSTAMP_EN`

Derived widths (not parameters):
- `CW` = `$clog2(DEPTH)+1`
- `ENTRY_W` = `XLEN+REG_ADDR_W+XLEN`, plus `TS_W` when timestamps are enabled

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high
- `i_wb_en`  in  1  register-file write strobe
- `i_wb_rd`  in  REG_ADDR_W  destination register
- `i_wb_data`  in  XLEN  write data
- `i_wb_pc`  in  XLEN  PC of the writing instruction
- `i_arm`  in  1  single-cycle pulse that clears the buffer and starts capture
- `i_trig_pc`  in  XLEN  trigger PC; sampled on every write
- `i_post_cnt`  in  CW  number of post-trigger writes; clamped to DEPTH-1
- `o_rd_valid`  out  1  readout entry available
- `i_rd_ready`  in  1  readout consumer ready
- `o_rd_data`  out  ENTRY_W  entry, packed as {[ts], pc, rd, data}
- `o_state`  out  2  encoding: 0 IDLE, 1 ARMED, 2 POST, 3 DONE
- `o_count`  out  CW  valid entries held
- `o_overflow`  out  1  oldest entries were overwritten since arm

## Operation
A recorded write is any cycle with `i_wb_en`=1 and `i_wb_rd`≠0. Writes to x0 are neither stored nor trigger-checked.

States and transitions:
- **IDLE:** recorded writes are ignored. `i_arm` → ARMED.
- **`i_arm` in any state:**
  - `wr_ptr`, `o_count`, `o_overflow` and the post counter are cleared; next state is ARMED.
  - `i_arm` has priority over a write in the same cycle; that write is dropped.
- **ARMED:**
  - Each recorded write stores its entry at `wr_ptr`; `wr_ptr` increments modulo DEPTH.
  - `o_count` saturates at DEPTH.
  - A store while `o_count`==DEPTH sets `o_overflow` (sticky until the next arm or reset).
- **Trigger:** a recorded write in ARMED with `i_wb_pc`==`i_trig_pc`.
  - The trigger entry itself is stored.
  - Clamped `i_post_cnt` is latched into `remain`.
  - If `remain`==0, next state is DONE; otherwise POST.
- **POST:**
  - Recorded writes are stored exactly as in ARMED, and each decrements `remain`.
  - The write that brings `remain` to 0 is stored, and the next state is DONE.
  - Further PC matches are ignored.
  - The clamp to DEPTH-1 guarantees the trigger entry is never overwritten.
- **DONE:**
  - Writes are ignored.
  - Read pointer = `wr_ptr` − `o_count` (mod DEPTH), so entries come out oldest first.
  - `o_rd_valid` = (`o_count`≠0).
  - Each `o_rd_valid`&`i_rd_ready` handshake pops one entry and decrements `o_count`.
  - The pop that empties the buffer returns the state to IDLE.
  - `o_rd_data` is held stable while valid and not ready.
- **Reset:** mid-operation reset discards all contents. All outputs are 0 and the state is IDLE.

## Timing
- All state, pointers and storage update on the rising edge of `clk`; no combinational path from `i_wb_*` to outputs.
- **State visibility:** a trigger or final POST write on edge N is visible as the new `o_state` and `o_count` after edge N.
- **Readout timing:**
  - `o_rd_valid` rises in the first cycle that `o_state`==3.
  - `o_rd_data` is driven combinationally from the storage array at the read pointer.
  - Throughput is one pop per cycle.
- **Arm latency:** `i_arm` on edge N; a write on edge N+1 is the first one captured.
- **Reset values:** `o_rd_valid`=0, `o_rd_data`=0, `o_state`=0, `o_count`=0, `o_overflow`=0.

## Configuration
- **`TRACE_TSTAMP_EN` defined:**
  - A `TS_W`-bit cycle counter increments every cycle, wraps, and is cleared by reset and by `i_arm`.
  - Its value at the store edge is placed in the upper `TS_W` bits of each entry.
- **`TRACE_TSTAMP_EN` undefined:** no counter; `ENTRY_W` excludes `TS_W`.

## Test plan
- **Basic capture and drain:** reset, arm, then 3 writes (rd 1/2/3, data 0xA/0xB/0xC, PC 0x0/0x4/0x8) with `i_trig_pc`=0x8 and `i_post_cnt`=0.
  - State 3 the cycle after the third write, `o_count`=3.
  - Drain with ready held high: entries come out in order 1, 2, 3, then state returns to 0.
- **Overflow:** DEPTH=16, arm, 20 writes with data 0..19, trigger on write 19.
  - `o_overflow`=1, `o_count`=16, readout data 4..19.
- **Post count:** trigger at write 5 (data 5), `i_post_cnt`=3, writes continue.
  - DONE after data 8; a second PC match during POST is ignored.
  - `i_post_cnt`=20 clamps to 15.
- **x0 and arm priority:** rd=0 writes whose PC equals `i_trig_pc` produce no entry and no trigger. A write coincident with `i_arm` is not captured.
- **Backpressure:** in DONE, `i_rd_ready` toggles randomly; `o_rd_data` is stable while not ready, with no duplicate or lost entries.
- **Reset mid-POST, then timestamps:** reset during POST → all outputs 0 the next cycle. With `TRACE_TSTAMP_EN`, two writes 5 cycles apart carry timestamps differing by 5.
